// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared encodings and defaults for the data memory responder
package data_mem_responder_pkg;

    localparam logic [1:0] MEM_IDLE = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] MEM_RESP = 2'd2;

    localparam int unsigned MEM_DEPTH_WORDS = 256;
    localparam int unsigned MEM_WAIT_CYCLES = 2;

    // Misaligned byte address or word index beyond the array.
    function automatic logic addr_bad(input logic [15:0] addr, input int unsigned depth);
        return addr[0] || ({17'd0, addr[15:1]} >= depth);
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// rtl/data_mem_array.sv - word storage with synchronous write, registered read and reset clear
module data_mem_array
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = MEM_DEPTH_WORDS,
    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);

    logic [15:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
                mem[i] <= 16'h0000;
            end
            rdata <= 16'h0000;
        end else begin
            if (we) begin
                mem[addr] <= wdata;
            end
            if (re) begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - single-outstanding LOAD/STOR responder with fixed wait and busy stall
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = MEM_DEPTH_WORDS,
    parameter int unsigned WAIT_CYCLES = MEM_WAIT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_busy
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic        lat_write;
    logic [15:0] lat_addr;
    logic [15:0] lat_wdata;
    logic        resp_is_load;
    logic [15:0] arr_rdata;

    logic        accept;
    logic        enter_resp;
    logic        cur_write;
    logic [15:0] cur_addr;
    logic [15:0] cur_wdata;
    logic        cur_bad;

    assign accept = (state == MEM_IDLE) && req_valid;
    assign enter_resp = (accept && (WAIT_CYCLES == 0)) ||
                        ((state == MEM_WAIT) && (cnt <= 4'd1));

    // With no wait the commit happens on the accept edge, before the latch holds the request.
    assign cur_write = (state == MEM_IDLE) ? req_write : lat_write;
    assign cur_addr  = (state == MEM_IDLE) ? req_addr  : lat_addr;
    assign cur_wdata = (state == MEM_IDLE) ? req_wdata : lat_wdata;
    assign cur_bad   = addr_bad(cur_addr, DEPTH_WORDS);

    assign req_ready  = (state == MEM_IDLE);
    assign resp_valid = (state == MEM_RESP);
    assign mem_busy   = (state != MEM_IDLE) || req_valid;
    assign resp_rdata = resp_is_load ? arr_rdata : 16'h0000;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= MEM_IDLE;
            cnt          <= 4'd0;
            lat_write    <= 1'b0;
            lat_addr     <= 16'h0000;
            lat_wdata    <= 16'h0000;
            resp_err     <= 1'b0;
            resp_is_load <= 1'b0;
        end else begin
            case (state)
                MEM_IDLE: begin
                    if (req_valid) begin
                        lat_write <= req_write;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        cnt       <= 4'(WAIT_CYCLES);
                        state     <= (WAIT_CYCLES == 0) ? MEM_RESP : MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt <= 4'd1) begin
                        state <= MEM_RESP;
                    end
                end
                MEM_RESP: state <= MEM_IDLE;
                default:  state <= MEM_IDLE;
            endcase
            if (enter_resp) begin
                resp_err     <= cur_bad;
                resp_is_load <= !cur_write && !cur_bad;
            end
        end
    end

    data_mem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (enter_resp && cur_write && !cur_bad),
        .re    (enter_resp && !cur_write && !cur_bad),
        .addr  (cur_addr[AW:1]),
        .wdata (cur_wdata),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - table-driven scoreboard bench for data_mem_responder
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0, req_write = 1'b0;
    logic [15:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err, mem_busy;
    logic [15:0] resp_rdata;

    logic        z_valid = 1'b0, z_write = 1'b0;
    logic [15:0] z_addr = '0, z_wdata = '0;
    logic        z_ready, z_resp_valid, z_resp_err, z_busy;
    logic [15:0] z_resp_rdata;

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_busy(mem_busy)
    );

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(z_valid), .req_write(z_write),
        .req_addr(z_addr), .req_wdata(z_wdata), .req_ready(z_ready),
        .resp_valid(z_resp_valid), .resp_rdata(z_resp_rdata), .resp_err(z_resp_err),
        .mem_busy(z_busy)
    );

    typedef struct {
        logic        w;
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] er;
        logic        ee;
    } vec_t;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    bit zsel = 1'b0;
    exp_t q[$];
    exp_t q0[$];
    vec_t vt[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resp_valid) begin
            exp_t e;
            pulses++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got resp_valid=1 expected 0");
            end else begin
                e = q.pop_front();
                check("resp_rdata", {16'd0, resp_rdata}, {16'd0, e.rdata});
                check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
            end
        end
    end

    always @(negedge clk) begin
        if (z_resp_valid) begin
            exp_t e;
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp0: got resp_valid=1 expected 0");
            end else begin
                e = q0.pop_front();
                check("resp0_rdata", {16'd0, z_resp_rdata}, {16'd0, e.rdata});
                check("resp0_err", {31'd0, z_resp_err}, {31'd0, e.err});
            end
        end
    end

    task automatic drive(input logic v, input logic w, input logic [15:0] a, input logic [15:0] d);
        if (zsel) begin
            z_valid = v; z_write = w; z_addr = a; z_wdata = d;
        end else begin
            req_valid = v; req_write = w; req_addr = a; req_wdata = d;
        end
    endtask

    // One request: scoreboard entry, latency, ready/busy windows and output hold.
    task automatic issue(input vec_t v);
        exp_t e;
        int lat, rdy_low, busy, exp_lat;
        exp_lat = zsel ? 1 : 3;
        @(negedge clk);
        drive(1'b1, v.w, v.a, v.d);
        e.rdata = v.er;
        e.err = v.ee;
        if (zsel) q0.push_back(e); else q.push_back(e);
        #1;
        busy = (zsel ? z_busy : mem_busy) ? 1 : 0;
        check("busy_same_cycle", busy, 1);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
        lat = 0;
        rdy_low = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (!(zsel ? z_ready : req_ready)) rdy_low++;
            if (zsel ? z_busy : mem_busy) busy++;
            if (zsel ? z_resp_valid : resp_valid) begin
                lat = c;
                break;
            end
        end
        check("resp_latency", lat, exp_lat);
        check("ready_low_cycles", rdy_low, exp_lat);
        check("busy_cycles", busy, exp_lat + 1);
        repeat (2) @(negedge clk);
        check("idle_ready", {31'd0, zsel ? z_ready : req_ready}, 1);
        check("hold_rdata", {16'd0, zsel ? z_resp_rdata : resp_rdata}, {16'd0, v.er});
        check("hold_err", {31'd0, zsel ? z_resp_err : resp_err}, {31'd0, v.ee});
    endtask

    initial begin
        vt[0]  = '{1'b0, 16'h0010, 16'h0000, 16'h0000, 1'b0};
        vt[1]  = '{1'b1, 16'h00A4, 16'hBEEF, 16'h0000, 1'b0};
        vt[2]  = '{1'b0, 16'h00A4, 16'h0000, 16'hBEEF, 1'b0};
        vt[3]  = '{1'b1, 16'h0005, 16'h1234, 16'h0000, 1'b1};
        vt[4]  = '{1'b0, 16'h0004, 16'h0000, 16'h0000, 1'b0};
        vt[5]  = '{1'b0, 16'h0200, 16'h0000, 16'h0000, 1'b1};
        vt[6]  = '{1'b1, 16'h01FE, 16'h5A5A, 16'h0000, 1'b0};
        vt[7]  = '{1'b0, 16'h01FE, 16'h0000, 16'h5A5A, 1'b0};
        vt[8]  = '{1'b0, 16'h00A5, 16'h0000, 16'h0000, 1'b1};
        vt[9]  = '{1'b1, 16'hFFFE, 16'h7777, 16'h0000, 1'b1};
        vt[10] = '{1'b0, 16'h00A4, 16'h0000, 16'hBEEF, 1'b0};
        vt[11] = '{1'b0, 16'h01FC, 16'h0000, 16'h0000, 1'b0};

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 1);
        check("rst_mem_busy", {31'd0, mem_busy}, 0);
        check("rst_resp_valid", {31'd0, resp_valid}, 0);
        check("rst_resp_rdata", {16'd0, resp_rdata}, 0);
        check("rst_resp_err", {31'd0, resp_err}, 0);

        for (int i = 0; i < 12; i++) issue(vt[i]);

        // req_valid held through WAIT/RESP with a different store: must be ignored.
        begin
            int p0;
            exp_t e;
            vec_t v;
            @(negedge clk);
            p0 = pulses;
            drive(1'b1, 1'b0, 16'h01FE, 16'h0000);
            e.rdata = 16'h5A5A;
            e.err = 1'b0;
            q.push_back(e);
            @(posedge clk);
            #1;
            drive(1'b1, 1'b1, 16'h0010, 16'hDEAD);
            repeat (3) @(negedge clk);
            drive(1'b0, 1'b0, 16'h0000, 16'h0000);
            repeat (6) @(negedge clk);
            check("held_valid_pulses", pulses - p0, 1);
            v = '{1'b0, 16'h0010, 16'h0000, 16'h0000, 1'b0};
            issue(v);
        end

        // Reset in WAIT of a store aborts it with no response.
        begin
            int p0;
            vec_t v;
            @(negedge clk);
            p0 = pulses;
            drive(1'b1, 1'b1, 16'h0020, 16'hFFFF);
            @(posedge clk);
            #1;
            drive(1'b0, 1'b0, 16'h0000, 16'h0000);
            @(negedge clk);
            reset = 1'b1;
            @(posedge clk);
            #1 reset = 1'b0;
            @(negedge clk);
            check("abort_req_ready", {31'd0, req_ready}, 1);
            check("abort_mem_busy", {31'd0, mem_busy}, 0);
            repeat (6) @(negedge clk);
            check("abort_no_pulse", pulses - p0, 0);
            v = '{1'b0, 16'h0020, 16'h0000, 16'h0000, 1'b0};
            issue(v);
        end

        zsel = 1'b1;
        issue(vt[1]);
        issue(vt[2]);
        issue(vt[5]);

        repeat (3) @(negedge clk);
        check("queue_drained", q.size(), 0);
        check("queue0_drained", q0.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
